// File: rtl/max_serial_acc_if.sv
// max_serial_acc_if: sample-in / result-out handshake bundle for max_serial_acc
interface max_serial_acc_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, busy
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, busy
    );
endinterface

// File: rtl/max_serial_acc.sv
// max_serial_acc: nibble-serial running-maximum over FRAME_LEN samples; MAX_SERIAL_ACC_SIGNED_EN selects two's-complement compare
module max_serial_acc #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input logic             clk,
    input logic             rst_n,
    max_serial_acc_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int PW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [PW-1:0] LAST_NIB = PW'(NIB - 1);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [WIDTH-1:0] max_q, max_d, op_q, op_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             carry_q, carry_d;
    logic [3:0]       a, m, flip;
    logic             last_nib, lt;

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == OUTPUT;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_max   = max_q;
    assign bus.out_idx   = idx_q;

    // current nibble pair and chained "max < operand" bit, LSB nibble first
    always_comb begin
        last_nib = ptr_q == LAST_NIB;
`ifdef MAX_SERIAL_ACC_SIGNED_EN
        flip = {last_nib, 3'b000};
`else
        flip = 4'b0000;
`endif
        a  = 4'(op_q >> {ptr_q, 2'b00}) ^ flip;
        m  = 4'(max_q >> {ptr_q, 2'b00}) ^ flip;
        lt = (m < a) | ((m == a) & carry_q);
    end

    // next-state: accept, serial compare, result hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                if (cnt_q == '0) begin
                    max_d   = bus.in_data;
                    idx_d   = '0;
                    cnt_d   = IDX_W'(1);
                    state_d = (LAST_CNT == '0) ? OUTPUT : IDLE;
                end else begin
                    op_d    = bus.in_data;
                    carry_d = 1'b0;
                    ptr_d   = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                carry_d = lt;
                ptr_d   = ptr_q + 1'b1;
                if (last_nib) begin
                    max_d   = lt ? op_q : max_q;
                    idx_d   = lt ? cnt_q : idx_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_CNT) ? OUTPUT : IDLE;
                end
            end
            OUTPUT: if (bus.out_ready) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers, async reset aborts any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            op_q    <= '0;
            ptr_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            carry_q <= carry_d;
        end
    end
endmodule
